load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before the timeout error (8-bit counter, 1..255).
REQ-002 clk  in  1  global clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 lsu_valid  in  1  pipeline request strobe; sampled only in IDLE.
REQ-005 lsu_store  in  1  1 = store, 0 = load.
REQ-006 lsu_addr  in  32  byte address.
REQ-007 lsu_wdata  in  32  store data, right-aligned.
REQ-008 lsu_size  in  2  00/11 word, 01 halfword, 10 byte.
REQ-009 lsu_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load.
REQ-010 lsu_busy  out  1  request in flight; new requests ignored.
REQ-011 lsu_done  out  1  one-cycle completion pulse.
REQ-012 lsu_rdata  out  32  load result, held until the next accept.
REQ-013 lsu_error  out  1  qualifies lsu_done; the request failed.
REQ-014 lsu_err_code  out  2  00 none, 01 misaligned, 10 out of range, 11 timeout.
REQ-015 mem_valid, mem_rw, mem_addr[31:0], mem_wdata[31:0], mem_size[1:0], mem_unsigned  out  memory-side request; connect to memory valid, rw, addr, data_in, byte_half_word, is_load_unsigned.
REQ-016 mem_ready, mem_out_of_range  in  1 each; mem_rdata  in  32; connect to memory ready, out_of_range, data_out.

Function
REQ-017 States IDLE, ACCESS, DONE; reset state IDLE.
REQ-018 In IDLE, when lsu_valid = 1, the unit registers all request fields at the clock edge and sets lsu_busy.
- Aligned request: next state ACCESS.
- Misaligned request: next state DONE with err 01; mem_valid is never raised.
REQ-019 Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 00; byte access is always aligned.
REQ-020 In ACCESS, mem_valid = 1 and every mem_* output is driven from the registered fields; they stay stable until ACCESS exits.
REQ-021 In ACCESS, mem_out_of_range = 1 moves to DONE with err 10 and takes priority over mem_ready in the same cycle.
REQ-022 In ACCESS, mem_ready = 1 moves to DONE with err 00; loads capture mem_rdata into lsu_rdata, stores set lsu_rdata to 0.
REQ-023 The timeout counter clears on entry to ACCESS and increments each ACCESS cycle. When it equals TIMEOUT_CYCLES with no ready, the unit moves to DONE with err 11. mem_ready in that same cycle wins.
REQ-024 In DONE, lsu_done = 1 for exactly one cycle, with lsu_error = (err != 00). mem_valid = 0. Next state IDLE, with lsu_busy low.
REQ-025 Minimum latency: request accepted at edge N, mem_valid high from N, ready seen at edge N+1, lsu_done high in cycle N+1..N+2. Back-to-back requests are accepted from the IDLE cycle after DONE.
REQ-026 lsu_valid is ignored while lsu_busy = 1; there is no request queue.
REQ-027 lsu_err_code is held until the next accept.

Reset
REQ-028 While rst = 0, immediately: state IDLE, counter 0, mem_valid 0, mem_rw 0, lsu_busy 0, lsu_done 0, lsu_error 0, lsu_err_code 00, lsu_rdata 0, all other mem_* outputs 0.
REQ-029 Reset mid-ACCESS drops mem_valid asynchronously; no lsu_done is produced for the aborted request.

Structure
REQ-030 Package lsu_pkg holds the state enum, the size encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE) and the error-code constants.
REQ-031 Sub-module lsu_align_check is combinational: inputs addr[1:0] and size, output misaligned.

Verification
REQ-032 Word load at 0x100, memory returns 0xDEADBEEF after 3 cycles -> mem_valid held 3 cycles; done with rdata 0xDEADBEEF, error 0.
REQ-033 Halfword store at 0x102 -> mem_size 01, mem_addr 0x102, done error 0. A halfword store at 0x103 -> done the cycle after accept, err 01, mem_valid never high.
REQ-034 Load at 0x10000 with mem_out_of_range = 1 and mem_ready = 1 in the same cycle -> err 10.
REQ-035 TIMEOUT_CYCLES = 4, mem_ready stuck 0 -> done after 4 ACCESS cycles, err 11, mem_valid drops.
REQ-036 rst pulsed low in the second ACCESS cycle -> mem_valid 0 asynchronously, no done. A new request after reset completes normally.
REQ-037 lsu_valid held high throughout two requests -> second accept occurs only in the IDLE cycle after DONE; mem_* fields stable within each access.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - lsu_state_e : sequencing states (IDLE, ACCESS, DONE)
//   - SIZE_*      : access-size encodings on lsu_size / mem_size
//   - ERR_*       : completion error codes reported on lsu_err_code
//   - CNT_W       : width of the access timeout counter
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } lsu_state_e;

  // 2'b11 is also decoded as a word access.
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: combinational natural-alignment check.
//   addr       in  2  low address bits of the request
//   size       in  2  access size (SIZE_WORD/SIZE_HALF/SIZE_BYTE, 2'b11 = word)
//   misaligned out 1  request does not sit on its natural boundary
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] size,
  output logic       misaligned
);

  // Bytes are always aligned; halfwords need addr[0]=0; words need addr[1:0]=0.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr[0];
      default:   misaligned = (addr != 2'b00);
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store sequencer between the
// pipeline and a ready-based memory.
//   clk, rst           clock, asynchronous active-low reset
//   lsu_valid/store/addr/wdata/size/unsigned   pipeline request (sampled in IDLE)
//   lsu_busy/done/rdata/error/err_code         pipeline status/result (registered)
//   mem_valid/rw/addr/wdata/size/unsigned      memory request (registered)
//   mem_ready/out_of_range/rdata               memory response
// TIMEOUT_CYCLES bounds the number of ACCESS cycles (1..255).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  input  logic        lsu_store,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_error,
  output logic [1:0]  lsu_err_code,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  input  logic        mem_ready,
  input  logic        mem_out_of_range,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             misaligned_s;
  logic             access_end_s;
  logic [1:0]       access_err_s;

  lsu_align_check u_align (
    .addr       (lsu_addr[1:0]),
    .size       (lsu_size),
    .misaligned (misaligned_s)
  );

  // Resolve how an ACCESS cycle ends: out-of-range beats ready, ready beats timeout.
  always_comb begin
    cnt_next_s   = cnt_r + 8'd1;
    access_end_s = 1'b0;
    access_err_s = ERR_NONE;
    if (mem_out_of_range) begin
      access_end_s = 1'b1;
      access_err_s = ERR_RANGE;
    end else if (mem_ready) begin
      access_end_s = 1'b1;
      access_err_s = ERR_NONE;
    end else if (cnt_next_s == TIMEOUT_LIMIT) begin
      access_end_s = 1'b1;
      access_err_s = ERR_TIMEOUT;
    end else begin
      access_end_s = 1'b0;
      access_err_s = ERR_NONE;
    end
  end

  // Request sequencer with all pipeline- and memory-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      lsu_busy     <= 1'b0;
      lsu_done     <= 1'b0;
      lsu_rdata    <= 32'd0;
      lsu_error    <= 1'b0;
      lsu_err_code <= ERR_NONE;
      mem_valid    <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      mem_size     <= 2'b00;
      mem_unsigned <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          lsu_done  <= 1'b0;
          lsu_error <= 1'b0;
          if (lsu_valid) begin
            lsu_busy     <= 1'b1;
            mem_rw       <= lsu_store;
            mem_addr     <= lsu_addr;
            mem_wdata    <= lsu_wdata;
            mem_size     <= lsu_size;
            mem_unsigned <= lsu_unsigned;
            lsu_rdata    <= 32'd0;
            cnt_r        <= 8'd0;
            // Misaligned requests complete without ever touching memory.
            if (misaligned_s) begin
              state_r      <= ST_DONE;
              lsu_done     <= 1'b1;
              lsu_error    <= 1'b1;
              lsu_err_code <= ERR_MISALIGN;
            end else begin
              state_r      <= ST_ACCESS;
              mem_valid    <= 1'b1;
              lsu_err_code <= ERR_NONE;
            end
          end else begin
            lsu_busy <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (access_end_s) begin
            state_r      <= ST_DONE;
            mem_valid    <= 1'b0;
            lsu_done     <= 1'b1;
            lsu_error    <= (access_err_s != ERR_NONE);
            lsu_err_code <= access_err_s;
            // Only a successful load returns data; stores and failures report zero.
            if ((access_err_s == ERR_NONE) && !mem_rw) begin
              lsu_rdata <= mem_rdata;
            end else begin
              lsu_rdata <= 32'd0;
            end
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        ST_DONE: begin
          state_r   <= ST_IDLE;
          lsu_done  <= 1'b0;
          lsu_error <= 1'b0;
          lsu_busy  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_valid <= 1'b0;
          lsu_done  <= 1'b0;
          lsu_error <= 1'b0;
          lsu_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed, self-checking bench for load_store_unit
// (built with TIMEOUT_CYCLES = 4 so the timeout path is reachable quickly).
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_store;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_error;
  logic [1:0]  lsu_err_code;
  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        mem_ready;
  logic        mem_out_of_range;
  logic [31:0] mem_rdata;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_valid        (lsu_valid),
    .lsu_store        (lsu_store),
    .lsu_addr         (lsu_addr),
    .lsu_wdata        (lsu_wdata),
    .lsu_size         (lsu_size),
    .lsu_unsigned     (lsu_unsigned),
    .lsu_busy         (lsu_busy),
    .lsu_done         (lsu_done),
    .lsu_rdata        (lsu_rdata),
    .lsu_error        (lsu_error),
    .lsu_err_code     (lsu_err_code),
    .mem_valid        (mem_valid),
    .mem_rw           (mem_rw),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_size         (mem_size),
    .mem_unsigned     (mem_unsigned),
    .mem_ready        (mem_ready),
    .mem_out_of_range (mem_out_of_range),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic us);
    lsu_valid    = 1'b1;
    lsu_store    = st;
    lsu_addr     = a;
    lsu_wdata    = wd;
    lsu_size     = sz;
    lsu_unsigned = us;
  endtask

  initial begin
    rst = 1'b0; lsu_valid = 1'b0; lsu_store = 1'b0; lsu_addr = 32'd0;
    lsu_wdata = 32'd0; lsu_size = 2'b00; lsu_unsigned = 1'b0;
    mem_ready = 1'b0; mem_out_of_range = 1'b0; mem_rdata = 32'd0;

    // Reset values, before any clock edge.
    #2;
    chk("rst_busy",     32'(lsu_busy),     32'd0);
    chk("rst_done",     32'(lsu_done),     32'd0);
    chk("rst_mem_valid",32'(mem_valid),    32'd0);
    chk("rst_err_code", 32'(lsu_err_code), 32'd0);
    chk("rst_rdata",    lsu_rdata,         32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Word load at 0x100, ready in the third ACCESS cycle.
    req(1'b0, 32'h0000_0100, 32'd0, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("ld_busy",      32'(lsu_busy),  32'd1);
    chk("ld_valid_c1",  32'(mem_valid), 32'd1);
    chk("ld_addr",      mem_addr,       32'h0000_0100);
    chk("ld_rw",        32'(mem_rw),    32'd0);
    tick();
    chk("ld_valid_c2",  32'(mem_valid), 32'd1);
    chk("ld_done_c2",   32'(lsu_done),  32'd0);
    tick();
    chk("ld_valid_c3",  32'(mem_valid), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("ld_done",      32'(lsu_done),  32'd1);
    chk("ld_error",     32'(lsu_error), 32'd0);
    chk("ld_rdata",     lsu_rdata,      32'hDEAD_BEEF);
    chk("ld_valid_end", 32'(mem_valid), 32'd0);
    tick();
    chk("ld_done_pulse",32'(lsu_done),  32'd0);
    chk("ld_busy_idle", 32'(lsu_busy),  32'd0);
    chk("ld_rdata_hold",lsu_rdata,      32'hDEAD_BEEF);

    // Halfword store at 0x102, minimum latency.
    req(1'b1, 32'h0000_0102, 32'h0000_1234, 2'b01, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("sh_size",  32'(mem_size),  32'd1);
    chk("sh_addr",  mem_addr,       32'h0000_0102);
    chk("sh_rw",    32'(mem_rw),    32'd1);
    chk("sh_wdata", mem_wdata,      32'h0000_1234);
    chk("sh_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("sh_done",  32'(lsu_done),  32'd1);
    chk("sh_error", 32'(lsu_error), 32'd0);
    chk("sh_rdata", lsu_rdata,      32'd0);
    tick();

    // Halfword store at 0x103: misaligned, memory untouched.
    req(1'b1, 32'h0000_0103, 32'h0000_5678, 2'b01, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("mis_done",  32'(lsu_done),     32'd1);
    chk("mis_error", 32'(lsu_error),    32'd1);
    chk("mis_code",  32'(lsu_err_code), 32'd1);
    chk("mis_valid", 32'(mem_valid),    32'd0);
    tick();
    chk("mis_done_pulse", 32'(lsu_done),     32'd0);
    chk("mis_busy_idle",  32'(lsu_busy),     32'd0);
    chk("mis_code_hold",  32'(lsu_err_code), 32'd1);
    chk("mis_valid_idle", 32'(mem_valid),    32'd0);

    // Word (size 11) at 0x002: misaligned.
    req(1'b0, 32'h0000_0002, 32'd0, 2'b11, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("misw_code",  32'(lsu_err_code), 32'd1);
    chk("misw_valid", 32'(mem_valid),    32'd0);
    tick();

    // Byte load at 0x103, unsigned: always aligned.
    req(1'b0, 32'h0000_0103, 32'd0, 2'b10, 1'b1);
    tick();
    lsu_valid = 1'b0;
    chk("lb_valid",    32'(mem_valid),    32'd1);
    chk("lb_size",     32'(mem_size),     32'd2);
    chk("lb_unsigned", 32'(mem_unsigned), 32'd1);
    chk("lb_code_clr", 32'(lsu_err_code), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h0000_00FF;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("lb_rdata", lsu_rdata, 32'h0000_00FF);
    tick();

    // Out of range with ready in the same cycle: range error wins.
    req(1'b0, 32'h0001_0000, 32'd0, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    mem_out_of_range = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_out_of_range = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("oor_done",  32'(lsu_done),     32'd1);
    chk("oor_error", 32'(lsu_error),    32'd1);
    chk("oor_code",  32'(lsu_err_code), 32'd2);
    chk("oor_rdata", lsu_rdata,         32'd0);
    tick();

    // Timeout: ready stuck low, four ACCESS cycles then err 11.
    req(1'b0, 32'h0000_0200, 32'd0, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("to_valid_c1", 32'(mem_valid), 32'd1);
    tick();
    chk("to_valid_c2", 32'(mem_valid), 32'd1);
    tick();
    chk("to_valid_c3", 32'(mem_valid), 32'd1);
    tick();
    chk("to_valid_c4", 32'(mem_valid), 32'd1);
    chk("to_done_c4",  32'(lsu_done),  32'd0);
    tick();
    chk("to_done",     32'(lsu_done),     32'd1);
    chk("to_code",     32'(lsu_err_code), 32'd3);
    chk("to_error",    32'(lsu_error),    32'd1);
    chk("to_valid_end",32'(mem_valid),    32'd0);
    tick();

    // Ready in the final (fourth) ACCESS cycle beats the timeout.
    req(1'b0, 32'h0000_0300, 32'd0, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    tick();
    tick();
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("tor_done",  32'(lsu_done),     32'd1);
    chk("tor_code",  32'(lsu_err_code), 32'd0);
    chk("tor_rdata", lsu_rdata,         32'hCAFE_F00D);
    tick();

    // Reset in the second ACCESS cycle.
    req(1'b0, 32'h0000_0400, 32'd0, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    tick();
    chk("ra_valid_c2", 32'(mem_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ra_valid_async", 32'(mem_valid), 32'd0);
    chk("ra_busy_async",  32'(lsu_busy),  32'd0);
    tick();
    chk("ra_done_r0", 32'(lsu_done), 32'd0);
    rst = 1'b1;
    tick();
    chk("ra_done_r1", 32'(lsu_done),  32'd0);
    chk("ra_valid_r1",32'(mem_valid), 32'd0);
    tick();
    chk("ra_done_r2", 32'(lsu_done), 32'd0);
    req(1'b1, 32'h0000_0404, 32'hA5A5_0001, 2'b00, 1'b0);
    tick();
    lsu_valid = 1'b0;
    chk("ra_new_valid", 32'(mem_valid), 32'd1);
    chk("ra_new_addr",  mem_addr,       32'h0000_0404);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("ra_new_done",  32'(lsu_done),  32'd1);
    chk("ra_new_error", 32'(lsu_error), 32'd0);
    tick();

    // lsu_valid held high across two requests.
    req(1'b0, 32'h0000_0500, 32'd0, 2'b00, 1'b0);
    tick();
    chk("b2b_a_addr", mem_addr,       32'h0000_0500);
    lsu_addr = 32'h0000_0504;
    lsu_store = 1'b1;
    tick();
    chk("b2b_a_stable", mem_addr,     32'h0000_0500);
    chk("b2b_a_rw",     32'(mem_rw),  32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    chk("b2b_a_done",  32'(lsu_done),  32'd1);
    chk("b2b_a_addr2", mem_addr,       32'h0000_0500);
    chk("b2b_a_rdata", lsu_rdata,      32'h1111_2222);
    tick();
    chk("b2b_idle_busy",  32'(lsu_busy),  32'd0);
    chk("b2b_idle_valid", 32'(mem_valid), 32'd0);
    tick();
    lsu_valid = 1'b0;
    chk("b2b_b_busy",  32'(lsu_busy),  32'd1);
    chk("b2b_b_valid", 32'(mem_valid), 32'd1);
    chk("b2b_b_addr",  mem_addr,       32'h0000_0504);
    chk("b2b_b_rw",    32'(mem_rw),    32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("b2b_b_done",  32'(lsu_done),  32'd1);
    chk("b2b_b_rdata", lsu_rdata,      32'd0);
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
